// File: rtl/keypad_entry_if.sv
// State/value link between the keypad entry front end (master) and the display (slave).
interface keypad_entry_if;
    logic [1:0]  state;
    logic [31:0] val_a;
    logic [31:0] val_b;
    logic [31:0] acc;
    logic        key_evt;
    logic [3:0]  key_code;

    modport master (output state, val_a, val_b, acc, key_evt, key_code);
    modport slave  (input  state, val_a, val_b, acc, key_evt, key_code);
endinterface

// File: rtl/keypad_entry.sv
// 4x4 keypad scanner, debouncer and two-operand decimal entry FSM.
// Optional KEYPAD_BACKSPACE_EN: key E deletes the last typed digit.
module keypad_entry #(
    parameter int unsigned SCAN_DIV   = 1000,
    parameter int unsigned DEB_SCANS  = 4,
    parameter int unsigned MAX_DIGITS = 9
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [3:0]     col_in,
    output logic [3:0]     row_out,
    keypad_entry_if.master disp
);
    localparam int unsigned DIVW = $clog2(SCAN_DIV);
    localparam int unsigned DEBW = $clog2(DEB_SCANS + 1);
    localparam int unsigned CNTW = $clog2(MAX_DIGITS + 1);

    typedef enum logic [1:0] {
        ST_A     = 2'b00,
        ST_B     = 2'b01,
        ST_READY = 2'b10,
        ST_SHOW  = 2'b11
    } state_t;

    state_t            st;
    logic [3:0]        col_s1, col_s2;
    logic [DIVW-1:0]   div_cnt;
    logic [1:0]        row_idx;
    logic [1:0]        scan_n;
    logic [3:0]        scan_code;
    logic [3:0]        cand;
    logic              cand_valid;
    logic              armed;
    logic [DEBW-1:0]   deb_cnt;
    logic [CNTW-1:0]   count;
    logic [31:0]       val_a, val_b, acc;
    logic              key_evt;
    logic [3:0]        key_code;

    function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
            4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
            4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
            4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  default: k = 4'hD;
        endcase
        return k;
    endfunction

    // Per-row column decode: row_n saturates at 2 (meaning "two or more keys").
    logic [3:0]      lows;
    logic [1:0]      row_n;
    logic [1:0]      col_idx;
    logic [2:0]      scan_sum;
    logic [1:0]      scan_n_next;
    logic [3:0]      code_next;
    logic [DEBW-1:0] deb_next;
    logic            slot_end;

    always_comb begin
        lows    = ~col_s2;
        row_n   = '0;
        col_idx = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (lows[i]) begin
                col_idx = 2'(i);
                if (row_n != 2'd2) row_n = row_n + 2'd1;
            end
        end
        scan_sum    = {1'b0, scan_n} + {1'b0, row_n};
        scan_n_next = (scan_sum >= 3'd2) ? 2'd2 : scan_sum[1:0];
        code_next   = (row_n == 2'd1) ? keymap(row_idx, col_idx) : scan_code;
        if (cand_valid && cand == code_next)
            deb_next = (deb_cnt == DEBW'(DEB_SCANS)) ? deb_cnt : deb_cnt + DEBW'(1);
        else
            deb_next = DEBW'(1);
        slot_end = (div_cnt == DIVW'(SCAN_DIV - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_s1     <= '1;
            col_s2     <= '1;
            div_cnt    <= '0;
            row_idx    <= '0;
            row_out    <= 4'b1110;
            scan_n     <= '0;
            scan_code  <= '0;
            cand       <= '0;
            cand_valid <= 1'b0;
            armed      <= 1'b1;
            deb_cnt    <= '0;
            key_evt    <= 1'b0;
            key_code   <= '0;
            count      <= '0;
            val_a      <= '0;
            val_b      <= '0;
            acc        <= '0;
            st         <= ST_A;
        end else begin
            col_s1  <= col_in;
            col_s2  <= col_s1;
            key_evt <= 1'b0;

            if (slot_end) begin
                div_cnt <= '0;
                row_idx <= row_idx + 2'd1;
                row_out <= {row_out[2:0], row_out[3]};
                if (row_idx == 2'd3) begin
                    scan_n <= '0;
                    if (scan_n_next == 2'd1) begin
                        cand       <= code_next;
                        cand_valid <= 1'b1;
                        deb_cnt    <= deb_next;
                        if (armed && deb_next == DEBW'(DEB_SCANS)) begin
                            key_evt  <= 1'b1;
                            key_code <= code_next;
                            armed    <= 1'b0;
                        end
                    end else begin
                        // Released and multi-key scans both re-arm the debouncer.
                        cand_valid <= 1'b0;
                        deb_cnt    <= '0;
                        armed      <= 1'b1;
                    end
                end else begin
                    scan_n    <= scan_n_next;
                    scan_code <= code_next;
                end
            end else begin
                div_cnt <= div_cnt + DIVW'(1);
            end

            if (key_evt) begin
                if (key_code <= 4'd9) begin
                    if ((st == ST_A || st == ST_B) && count < CNTW'(MAX_DIGITS)) begin
                        acc   <= acc * 32'd10 + {28'd0, key_code};
                        count <= count + CNTW'(1);
                    end
                end else begin
                    case (key_code)
                        4'hA: if (st == ST_A) begin
                            val_a <= acc;
                            acc   <= '0;
                            count <= '0;
                            st    <= ST_B;
                        end
                        4'hB: if (st == ST_B) begin
                            val_b <= acc;
                            acc   <= '0;
                            count <= '0;
                            st    <= ST_READY;
                        end
                        4'hC: begin
                            acc   <= '0;
                            val_a <= '0;
                            val_b <= '0;
                            count <= '0;
                            st    <= ST_A;
                        end
                        4'hD: if (st == ST_READY) st <= ST_SHOW;
`ifdef KEYPAD_BACKSPACE_EN
                        4'hE: if ((st == ST_A || st == ST_B) && count != '0) begin
                            acc   <= acc / 32'd10;
                            count <= count - CNTW'(1);
                        end
`endif
                        default: ;
                    endcase
                end
            end
        end
    end

    assign disp.state    = st;
    assign disp.val_a    = val_a;
    assign disp.val_b    = val_b;
    assign disp.acc      = acc;
    assign disp.key_evt  = key_evt;
    assign disp.key_code = key_code;
endmodule
